// File: rtl/clock_divider_mc.sv
// Multi-channel integer clock divider with shadowed, period-aligned register updates.
// Each channel emits a one-cycle tick and a pulse or ~50% square clock.
module clock_divider_mc #(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned DIV_W  = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_CH-1:0]         wr_en,
   input  logic [DIV_W-1:0]          div_in,
   input  logic                      mode_in,
   input  logic                      sync,
   output logic [NUM_CH-1:0]         tick_out,
   output logic [NUM_CH-1:0]         clk_out,
   output logic [NUM_CH-1:0]         pending,
   output logic [NUM_CH*DIV_W-1:0]   div_reg
);

   localparam int unsigned HW = DIV_W + 1;

   logic [DIV_W-1:0] div_a [NUM_CH];
   logic [DIV_W-1:0] div_s [NUM_CH];
   logic [DIV_W-1:0] cnt   [NUM_CH];
   logic [NUM_CH-1:0] mode_a;
   logic [NUM_CH-1:0] mode_s;
   logic [NUM_CH-1:0] pend;

   logic [NUM_CH-1:0] term;
   logic [NUM_CH-1:0] apply;
   logic [NUM_CH-1:0] sq_high;
   logic [HW-1:0]     half [NUM_CH];

   // Period end, apply strobe and square-wave high window (ceil(N/2) cycles).
   always_comb begin
      term    = '0;
      apply   = '0;
      sq_high = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         half[c]    = ({1'b0, div_a[c]} + HW'(2)) >> 1;
         term[c]    = (cnt[c] == div_a[c]);
         apply[c]   = term[c] | sync;
         sq_high[c] = ({1'b0, cnt[c]} < half[c]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            div_a[c] <= '0;
            div_s[c] <= '0;
            cnt[c]   <= '0;
         end
         mode_a   <= '0;
         mode_s   <= '0;
         pend     <= '0;
         tick_out <= '0;
         clk_out  <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (apply[c]) cnt[c] <= '0;
            else          cnt[c] <= cnt[c] + DIV_W'(1);

            // A write landing on the apply cycle bypasses the shadow entirely.
            if (apply[c]) begin
               if (wr_en[c]) begin
                  div_a[c]  <= div_in;
                  mode_a[c] <= mode_in;
                  pend[c]   <= 1'b0;
               end else if (pend[c]) begin
                  div_a[c]  <= div_s[c];
                  mode_a[c] <= mode_s[c];
                  pend[c]   <= 1'b0;
               end
            end else if (wr_en[c]) begin
               div_s[c]  <= div_in;
               mode_s[c] <= mode_in;
               pend[c]   <= 1'b1;
            end

            tick_out[c] <= term[c] & ~sync;
            if (mode_a[c]) clk_out[c] <= sync | sq_high[c];
            else           clk_out[c] <= term[c] & ~sync;
         end
      end
   end

   always_comb begin
      pending = pend;
      div_reg = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         div_reg[c*DIV_W +: DIV_W] = div_a[c];
      end
   end

endmodule

// File: tb/tb_clock_divider_mc.sv
// Scoreboard bench for clock_divider_mc: the driver pushes the expected outputs of
// each edge, a monitor pops and compares them just after that edge.
module tb_clock_divider_mc;

   localparam int unsigned NC = 2;
   localparam int unsigned DW = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NC-1:0]   wr_en;
   logic [DW-1:0]   div_in;
   logic            mode_in;
   logic            sync;
   logic [NC-1:0]   tick_out;
   logic [NC-1:0]   clk_out;
   logic [NC-1:0]   pending;
   logic [NC*DW-1:0] div_reg;

   clock_divider_mc #(.NUM_CH(NC), .DIV_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .div_in(div_in), .mode_in(mode_in),
      .sync(sync), .tick_out(tick_out), .clk_out(clk_out), .pending(pending),
      .div_reg(div_reg)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NC-1:0]    tick;
      logic [NC-1:0]    clko;
      logic [NC-1:0]    pend;
      logic [NC*DW-1:0] dreg;
   } exp_t;

   exp_t exp_q[$];
   int total = 0;
   int bad   = 0;

   // Period-level reference: active divide/mode, position within the period, shadow.
   int mdiv [NC];
   int mk   [NC];
   int msdiv[NC];
   bit msq  [NC];
   bit mssq [NC];
   bit mpend[NC];

   function automatic void model_reset();
      for (int c = 0; c < NC; c++) begin
         mdiv[c] = 0; mk[c] = 0; msdiv[c] = 0;
         msq[c] = 1'b0; mssq[c] = 1'b0; mpend[c] = 1'b0;
      end
   endfunction

   task automatic step(input logic [NC-1:0] wr, input int d, input bit m,
                       input bit sy, input bit rst);
      exp_t e;
      int   n;
      bit   term;
      @(negedge clk);
      rst_n   = ~rst;
      wr_en   = wr;
      div_in  = DW'(d);
      mode_in = m;
      sync    = sy;
      e = '0;
      if (rst) begin
         model_reset();
      end else begin
         for (int c = 0; c < NC; c++) begin
            n = mdiv[c] + 1;
            term = (mk[c] == n - 1);
            e.tick[c] = term && !sy;
            if (msq[c]) e.clko[c] = sy || (mk[c] < (n + 1) / 2);
            else        e.clko[c] = term && !sy;
            if (term || sy) begin
               mk[c] = 0;
               if (wr[c]) begin
                  mdiv[c] = d; msq[c] = m; mpend[c] = 1'b0;
               end else if (mpend[c]) begin
                  mdiv[c] = msdiv[c]; msq[c] = mssq[c]; mpend[c] = 1'b0;
               end
            end else begin
               mk[c]++;
               if (wr[c]) begin
                  msdiv[c] = d; mssq[c] = m; mpend[c] = 1'b1;
               end
            end
            e.pend[c] = mpend[c];
            e.dreg[c*DW +: DW] = DW'(mdiv[c]);
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step('0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   // Idle until channel c sits at period position pos (bounded).
   task automatic run_until(input int c, input int pos);
      for (int i = 0; i < 600 && mk[c] != pos; i++) idle(1);
      if (mk[c] != pos) begin
         bad++;
         $display("FAIL run_until ch%0d: position %0d never reached", c, pos);
      end
   endtask

   task automatic wait_applied(input int c);
      for (int i = 0; i < 600 && mpend[c]; i++) idle(1);
      if (mpend[c]) begin
         bad++;
         $display("FAIL wait_applied ch%0d: shadow never applied", c);
      end
   endtask

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endfunction

   // Monitor: outputs change only on posedge, so sample 1 time unit later.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("tick_out", 32'(tick_out), 32'(e.tick));
            check("clk_out",  32'(clk_out),  32'(e.clko));
            check("pending",  32'(pending),  32'(e.pend));
            check("div_reg",  32'(div_reg),  32'(e.dreg));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; wr_en = '0; div_in = '0; mode_in = 1'b0; sync = 1'b0;
      model_reset();

      // Reset overrides write and sync strobes.
      step(2'b11, 9, 1'b1, 1'b1, 1'b1);
      step('0, 0, 1'b0, 1'b0, 1'b1);
      idle(3);

      // Ch0 pulse divide-by-5 (bypass on the div=0 boundary).
      step(2'b01, 4, 1'b0, 1'b0, 1'b0);
      idle(12);

      // Ch1 square div=3 (1100), then div=4 (11100) written mid-period.
      step(2'b10, 3, 1'b1, 1'b0, 1'b0);
      idle(6);
      run_until(1, 1);
      step(2'b10, 4, 1'b1, 1'b0, 1'b0);
      idle(16);

      // Ch0 div=9, then writes at positions 3 and 6: last write wins.
      run_until(0, 1);
      step(2'b01, 9, 1'b0, 1'b0, 1'b0);
      wait_applied(0);
      run_until(0, 3);
      step(2'b01, 2, 1'b0, 1'b0, 1'b0);
      run_until(0, 6);
      step(2'b01, 5, 1'b0, 1'b0, 1'b0);
      idle(16);

      // Ch0 div=4, ch1 div=6 pulse, offset phases, then sync and run past the LCM.
      run_until(0, 1);
      step(2'b01, 4, 1'b0, 1'b0, 1'b0);
      run_until(1, 1);
      step(2'b10, 6, 1'b0, 1'b0, 1'b0);
      wait_applied(0);
      wait_applied(1);
      idle(3);
      step('0, 0, 1'b0, 1'b1, 1'b0);
      idle(40);

      // Sync coinciding with a write bypasses the shadow; square sync cycle drives 1.
      run_until(1, 2);
      step(2'b10, 255, 1'b1, 1'b1, 1'b0);
      idle(20);
      step('0, 0, 1'b0, 1'b1, 1'b0);
      idle(262);

      // Ch1 square N=2 and N=1.
      run_until(1, 5);
      step(2'b10, 1, 1'b1, 1'b0, 1'b0);
      wait_applied(1);
      idle(6);
      step(2'b10, 0, 1'b1, 1'b0, 1'b0);
      run_until(1, 0);
      idle(4);

      // Reset mid-period with a pending write and wr_en asserted.
      run_until(0, 1);
      step(2'b01, 7, 1'b1, 1'b0, 1'b0);
      step(2'b11, 3, 1'b1, 1'b0, 1'b1);
      idle(4);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
         bad++;
         $display("FAIL drain: %0d expected entries never compared", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
